ram_porta_scheduler: RTL and testbench

RAM_PORTA_SCHEDULER -- requirements
Module: ram_porta_scheduler

---
 rtl/ram_porta_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ram_porta_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_porta_scheduler.sv
// ram_porta_scheduler: shares RAM port A between a 32-bit word writer (sel)
// and a byte-wide CPU port. The sel writer gets a 4-beat little-endian
// write burst; the CPU gets single byte reads or writes. Arbitration happens
// only in IDLE and alternates when both requesters are waiting.
module ram_porta_scheduler #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  // sel word-write requester
  input  logic              sel_req,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic [31:0]       sel_wdata,
  output logic              sel_ack,
  // cpu byte requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // RAM port A
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SEL_WR      = 3'd1;
  localparam logic [2:0] S_SEL_ACK     = 3'd2;
  localparam logic [2:0] S_CPU_ACC     = 3'd3;
  localparam logic [2:0] S_CPU_RD_WAIT = 3'd4;
  localparam logic [2:0] S_CPU_RD_CAP  = 3'd5;

  logic [2:0]        state_q,       state_d;
  logic [1:0]        cnt_q,         cnt_d;
  logic              last_sel_q,    last_sel_d;
  logic [ADDR_W-1:0] addr_lat_q,    addr_lat_d;
  logic [31:0]       word_q,        word_d;
  logic              sel_ack_q,     sel_ack_d;
  logic              cpu_gnt_q,     cpu_gnt_d;
  logic              cpu_rvalid_q,  cpu_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q,   cpu_rdata_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q,    ram_data_d;
  logic              ram_wren_q,    ram_wren_d;
  logic              busy_q,        busy_d;

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so the port sees only registered values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_sel_d    = last_sel_q;
    addr_lat_d    = addr_lat_q;
    word_d        = word_q;
    cpu_rdata_d   = cpu_rdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    sel_ack_d     = 1'b0;
    cpu_gnt_d     = 1'b0;
    cpu_rvalid_d  = 1'b0;
    ram_wren_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // sel wins when alone, or when both wait and cpu was served last
        if (sel_req && (!cpu_req || !last_sel_q)) begin
          state_d       = S_SEL_WR;
          cnt_d         = 2'd0;
          last_sel_d    = 1'b1;
          addr_lat_d    = sel_addr;
          word_d        = sel_wdata;
          ram_address_d = sel_addr;
          ram_data_d    = DATA_W'(sel_wdata[7:0]);
          ram_wren_d    = 1'b1;
        end else if (cpu_req) begin
          state_d       = S_CPU_ACC;
          last_sel_d    = 1'b0;
          ram_address_d = cpu_addr;
          ram_data_d    = cpu_wdata;
          ram_wren_d    = cpu_we;
          cpu_gnt_d     = 1'b1;
        end
      end

      S_SEL_WR: begin
        if (cnt_q == 2'd3) begin
          state_d   = S_SEL_ACK;
          sel_ack_d = 1'b1;
        end else begin
          // word_q[7:0] is always the byte currently on the port
          cnt_d         = cnt_q + 2'd1;
          word_d        = word_q >> 8;
          ram_address_d = addr_lat_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          ram_data_d    = DATA_W'(word_d[7:0]);
          ram_wren_d    = 1'b1;
        end
      end

      S_SEL_ACK: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end

      S_CPU_ACC: begin
        // ram_wren_q still holds the accepted access type (1 = write)
        state_d = ram_wren_q ? S_IDLE : S_CPU_RD_WAIT;
      end

      S_CPU_RD_WAIT: begin
        // address held one more cycle; RAM data is valid at this edge
        state_d      = S_CPU_RD_CAP;
        cpu_rdata_d  = ram_q;
        cpu_rvalid_d = 1'b1;
      end

      S_CPU_RD_CAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 2'd0;
      last_sel_q    <= 1'b0;
      addr_lat_q    <= '0;
      word_q        <= '0;
      sel_ack_q     <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_sel_q    <= last_sel_d;
      addr_lat_q    <= addr_lat_d;
      word_q        <= word_d;
      sel_ack_q     <= sel_ack_d;
      cpu_gnt_q     <= cpu_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
    end
  end

  assign sel_ack     = sel_ack_q;
  assign cpu_gnt     = cpu_gnt_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram_porta_scheduler.sv
// Testbench for ram_porta_scheduler: a timeline model predicts every port
// event (write byte, sel_ack, cpu_gnt, cpu_rvalid) with its cycle number,
// and a monitor pops and compares whenever the DUT shows one.
module tb_ram_porta_scheduler;

  localparam int K_WR   = 0;
  localparam int K_SACK = 1;
  localparam int K_GNT  = 2;
  localparam int K_RVAL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_req, cpu_req, cpu_we;
  logic [18:0] sel_addr, cpu_addr;
  logic [31:0] sel_wdata;
  logic [7:0]  cpu_wdata;
  logic        sel_ack, cpu_gnt, cpu_rvalid, ram_wren, busy;
  logic [7:0]  cpu_rdata, ram_data, ram_q;
  logic [18:0] ram_address;

  ram_porta_scheduler #(.ADDR_W(19), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .sel_req(sel_req), .sel_addr(sel_addr), .sel_wdata(sel_wdata), .sel_ack(sel_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // cycle stamp: value seen at a negedge = index of the preceding posedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // environment RAM: synchronous write, registered read
  logic [7:0] ram_mem [0:524287];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_q <= ram_mem[ram_address];
  end

  typedef struct {
    int          kind;
    int          cyc;
    logic [18:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] ref_mem [0:524287];
  bit         m_last_sel;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic string kname(input int k);
    case (k)
      K_WR:    return "write";
      K_SACK:  return "sel_ack";
      K_GNT:   return "cpu_gnt";
      default: return "cpu_rvalid";
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  function automatic void push(input int k, input int c, input logic [18:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  // reference: a sel burst granted at cycle t; returns next arbitration cycle
  function automatic int model_sel(input logic [18:0] a, input logic [31:0] w, input int t);
    logic [18:0] ak;
    for (int k = 0; k < 4; k++) begin
      ak = a + 19'(k);
      push(K_WR, t + k, ak, w[8*k +: 8]);
      ref_mem[ak] = w[8*k +: 8];
    end
    push(K_SACK, t + 4, '0, '0);
    m_last_sel = 1'b1;
    return t + 6;
  endfunction

  // reference: a cpu access granted at cycle t; returns next arbitration cycle
  function automatic int model_cpu(input bit we, input logic [18:0] a, input logic [7:0] d, input int t);
    m_last_sel = 1'b0;
    if (we) begin
      push(K_WR, t, a, d);
      push(K_GNT, t, '0, '0);
      ref_mem[a] = d;
      return t + 2;
    end
    push(K_GNT, t, '0, '0);
    push(K_RVAL, t + 2, '0, ref_mem[a]);
    return t + 4;
  endfunction

  function automatic logic [18:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 19'h7FFFC + 19'($urandom_range(0, 3));
      1:       return 19'($urandom_range(0, 7));
      default: return 19'h30E50 + 19'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic observe(input int k, input logic [18:0] a, input logic [7:0] d);
    ev_t e;
    bit  ok;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_event",
            $sformatf("got %s addr=%h data=%h at cycle %0d, required no event", kname(k), a, d, cyc));
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == k) && (e.cyc == cyc) && busy;
      if (k == K_WR)   ok = ok && (e.addr == a) && (e.data == d);
      if (k == K_RVAL) ok = ok && (e.data == d);
      check(ok, kname(e.kind),
            $sformatf("got %s cyc=%0d addr=%h data=%h busy=%b, required %s cyc=%0d addr=%h data=%h busy=1",
                      kname(k), cyc, a, d, busy, kname(e.kind), e.cyc, e.addr, e.data));
    end
  endtask

  // monitor: every visible port event is matched against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (ram_wren)   observe(K_WR, ram_address, ram_data);
      if (sel_ack)    observe(K_SACK, '0, '0);
      if (cpu_gnt)    observe(K_GNT, '0, '0);
      if (cpu_rvalid) observe(K_RVAL, '0, cpu_rdata);
    end
  end

  task automatic check_cleared(input string tag);
    check({sel_ack, cpu_gnt, cpu_rvalid, ram_wren, busy} == 5'b0, {tag, "_ctrl"},
          $sformatf("got ack=%b gnt=%b rvalid=%b wren=%b busy=%b, required all 0",
                    sel_ack, cpu_gnt, cpu_rvalid, ram_wren, busy));
    check(cpu_rdata == 8'h0 && ram_address == 19'h0 && ram_data == 8'h0, {tag, "_data"},
          $sformatf("got rdata=%h addr=%h data=%h, required all 0", cpu_rdata, ram_address, ram_data));
  endtask

  // one scenario: optional sel (sel_n bursts back to back) and optional cpu
  // access raised d cycles after sel; requests held until ack/gnt
  task automatic run_scn(input bit sel_en, input int sel_n, input logic [18:0] sa, input logic [31:0] sw,
                         input bit cpu_en, input int d, input bit we, input logic [18:0] ca,
                         input logic [7:0] cw);
    int t, i, sel_need, cpu_need;
    bit sel_first, scramble;
    @(negedge clk); #1;
    t = cyc + 1;
    sel_first = sel_en && !(cpu_en && d == 0 && m_last_sel);
    if (sel_en && cpu_en) begin
      if (sel_first) begin
        t = model_sel(sa, sw, t);
        t = model_cpu(we, ca, cw, t);
      end else begin
        t = model_cpu(we, ca, cw, t);
        t = model_sel(sa, sw, t);
      end
    end else if (sel_en) begin
      for (int n = 0; n < sel_n; n++) t = model_sel(sa, sw, t);
    end else if (cpu_en) begin
      t = model_cpu(we, ca, cw, t);
    end
    sel_addr = sa; sel_wdata = sw; sel_req = sel_en;
    cpu_we = we; cpu_addr = ca; cpu_wdata = cw; cpu_req = cpu_en && (d == 0);
    sel_need = sel_en ? sel_n : 0;
    cpu_need = cpu_en ? 1 : 0;
    scramble = sel_first && (sel_n == 1);
    i = 0;
    while ((sel_need > 0 || cpu_need > 0) && i < 80) begin
      @(negedge clk); #1;
      i++;
      if (sel_req && sel_ack) begin
        sel_need--;
        if (sel_need == 0) begin
          sel_req = 1'b0; sel_addr = rand_addr(); sel_wdata = $urandom;
        end
      end
      if (cpu_req && cpu_gnt) begin
        cpu_need = 0; cpu_req = 1'b0;
        cpu_addr = rand_addr(); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
      end
      if (cpu_en && d > 0 && i == d) cpu_req = 1'b1;
      if (scramble && sel_req && i <= 3) begin
        sel_addr = rand_addr(); sel_wdata = $urandom;
      end
    end
    check(sel_need == 0 && cpu_need == 0, "handshake",
          $sformatf("got sel_need=%0d cpu_need=%0d after %0d cycles, required 0/0", sel_need, cpu_need, i));
    repeat (4 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  // reset in the middle of a sel burst (after byte 1 is written) or a cpu read
  task automatic reset_mid(input bit is_cpu, input logic [18:0] a, input logic [31:0] w);
    int          t;
    logic [18:0] ak;
    @(negedge clk); #1;
    t = cyc + 1;
    if (is_cpu) begin
      cpu_we = 1'b0; cpu_addr = a; cpu_req = 1'b1;
      push(K_GNT, t, '0, '0);
      repeat (2) @(negedge clk);
    end else begin
      sel_addr = a; sel_wdata = w; sel_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
        ak = a + 19'(k);
        push(K_WR, t + k, ak, w[8*k +: 8]);
        if (k < 2) ref_mem[ak] = w[8*k +: 8];
      end
      repeat (3) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1 check_cleared(is_cpu ? "mid_read_reset" : "mid_burst_reset");
    sel_req = 1'b0; cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_last_sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int k;
    logic [18:0] sa, ca;
    logic [31:0] sw;
    logic [7:0]  cw;
    bit          we;

    for (int i = 0; i < 524288; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    m_last_sel = 1'b0;
    rst = 1'b0;
    sel_req = 1'b0; sel_addr = '0; sel_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #1 check_cleared("reset");
    @(negedge clk);
    rst = 1'b1;

    // directed cases
    run_scn(1, 1, 19'h30E50, 32'h0000012C, 0, 0, 0, '0, '0);
    run_scn(0, 0, '0, '0, 1, 0, 1, 19'h00004, 8'hA5);
    run_scn(0, 0, '0, '0, 1, 0, 0, 19'h00004, 8'h00);
    run_scn(1, 1, 19'h00010, 32'h44332211, 1, 0, 0, 19'h00004, 8'h00);
    run_scn(1, 1, 19'h00020, 32'h88776655, 0, 0, 0, '0, '0);
    run_scn(1, 1, 19'h00030, 32'hCAFEF00D, 1, 0, 1, 19'h00006, 8'h5A);
    run_scn(1, 1, 19'h00040, 32'h01020304, 1, 3, 0, 19'h00006, 8'h00);
    run_scn(1, 1, 19'h7FFFE, 32'hDDCCBBAA, 0, 0, 0, '0, '0);
    run_scn(1, 2, 19'h00050, 32'h12345678, 0, 0, 0, '0, '0);

    // reset mid-burst: partial bytes stay, then a full burst and readback
    reset_mid(0, 19'h30E58, 32'h9ABCDEF0);
    for (int b = 0; b < 4; b++)
      run_scn(0, 0, '0, '0, 1, 0, 0, 19'h30E58 + 19'(b), 8'h00);
    run_scn(1, 1, 19'h30E58, 32'h0F1E2D3C, 0, 0, 0, '0, '0);
    for (int b = 0; b < 4; b++)
      run_scn(0, 0, '0, '0, 1, 0, 0, 19'h30E58 + 19'(b), 8'h00);
    reset_mid(1, 19'h00004, '0);
    run_scn(0, 0, '0, '0, 1, 0, 0, 19'h00004, 8'h00);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 4);
      sa = rand_addr(); sw = $urandom;
      ca = rand_addr(); cw = 8'($urandom); we = 1'($urandom);
      case (k)
        0:       run_scn(1, 1, sa, sw, 0, 0, we, ca, cw);
        1:       run_scn(0, 0, sa, sw, 1, 0, we, ca, cw);
        2:       run_scn(1, 1, sa, sw, 1, 0, we, ca, cw);
        3:       run_scn(1, 1, sa, sw, 1, $urandom_range(1, 5), we, ca, cw);
        default: run_scn(1, 2, sa, sw, 0, 0, we, ca, cw);
      endcase
    end

    repeat (10) @(negedge clk);
    check(exp_q.size() == 0, "drain",
          $sformatf("got %0d outstanding expected events, required 0", exp_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
